// File: rtl/product_table_writer.sv
// product_table_writer: fills a 2**(2N)-entry product table, one
// {a,b} address at a time, using an N-cycle shift-add multiplier.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - one-cycle request to begin a full table fill
//   wr_ready - memory accepts the pending write this cycle
//   wr_en    - write strobe; wr_addr/wr_data valid while high
//   wr_addr  - table address {a,b}
//   wr_data  - unsigned product a*b
//   busy     - fill in progress
//   done     - fill complete; sticky until next start
module product_table_writer #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           wr_ready,
    output logic           wr_en,
    output logic [2*N-1:0] wr_addr,
    output logic [2*N-1:0] wr_data,
    output logic           busy,
    output logic           done
);

    localparam int AW = 2 * N;
    localparam int BW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_mcand;
    logic [N-1:0]    r_mplier;
    logic [BW-1:0]   r_bit;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_wr_data;
    logic            r_busy;
    logic            r_done;

    logic [AW-1:0]   w_acc_next;
    logic            w_last_bit;
    logic            w_last_entry;

    // Multiplicand is pre-shifted each cycle, so adding it when the
    // current multiplier LSB is set is the same as acc += a << i.
    assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last_bit   = (r_bit == BW'(N - 1));
    assign w_last_entry = (r_cnt == {AW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_bit     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_mcand  <= {{N{1'b0}}, r_cnt[AW-1:N]};
                    r_mplier <= r_cnt[N-1:0];
                    r_acc    <= '0;
                    r_bit    <= '0;
                    r_state  <= S_MULT;
                end
                S_MULT: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_bit    <= r_bit + 1'b1;
                    if (w_last_bit) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt;
                        r_wr_data <= w_acc_next;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Outputs and counter hold until the memory takes it.
                    if (wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (w_last_entry) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_product_table_writer.sv
// tb_product_table_writer: scoreboard bench for product_table_writer
// with N=2 and N=4 instances sharing one clock.
module tb_product_table_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n2, start2, rdy2;
    logic       wr_en2, busy2, done2;
    logic [3:0] addr2, data2;

    logic       rst_n4, start4, rdy4;
    logic       wr_en4, busy4, done4;
    logic [7:0] addr4, data4;

    int checks = 0;
    int errors = 0;
    int nwr2   = 0;
    int nwr4   = 0;
    int n6_2   = 0;

    logic [7:0]  q2[$];
    logic [15:0] q4[$];

    product_table_writer #(.N(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n2),
        .start    (start2),
        .wr_ready (rdy2),
        .wr_en    (wr_en2),
        .wr_addr  (addr2),
        .wr_data  (data2),
        .busy     (busy2),
        .done     (done2)
    );

    product_table_writer #(.N(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n4),
        .start    (start4),
        .wr_ready (rdy4),
        .wr_en    (wr_en4),
        .wr_addr  (addr4),
        .wr_data  (data4),
        .busy     (busy4),
        .done     (done4)
    );

    // Inputs change at posedge+1, so at negedge wr_ready is the value
    // the next edge will see: wr_en && wr_ready here is an accepted write.
    always @(negedge clk) begin
        logic [7:0]  e2;
        logic [15:0] e4;
        if (wr_en2 && rdy2) begin
            nwr2++;
            if (addr2 == 4'd6) n6_2++;
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL sb2_extra: got addr %0d data %0d, expected no write",
                         addr2, data2);
            end else begin
                e2 = q2.pop_front();
                if ({addr2, data2} !== e2) begin
                    errors++;
                    $display("FAIL sb2_write: got addr %0d data %0d, expected addr %0d data %0d",
                             addr2, data2, e2[7:4], e2[3:0]);
                end
            end
        end
        if (wr_en4 && rdy4) begin
            nwr4++;
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL sb4_extra: got addr %0d data %0d, expected no write",
                         addr4, data4);
            end else begin
                e4 = q4.pop_front();
                if ({addr4, data4} !== e4) begin
                    errors++;
                    $display("FAIL sb4_write: got addr %0d data %0d, expected addr %0d data %0d",
                             addr4, data4, e4[15:8], e4[7:0]);
                end
            end
        end
    end

    task automatic push2();
        for (int i = 0; i < 16; i++)
            q2.push_back({4'(i), 4'((i >> 2) * (i & 3))});
    endtask

    task automatic push4();
        for (int i = 0; i < 256; i++)
            q4.push_back({8'(i), 8'((i >> 4) * (i & 15))});
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic pulse2();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n2 = 1'b0; start2 = 1'b0; rdy2 = 1'b1;
        rst_n4 = 1'b0; start4 = 1'b0; rdy4 = 1'b1;
        #2;
        checks++;
        if ({wr_en2, addr2, data2, busy2, done2} !== 11'd0) begin
            errors++;
            $display("FAIL reset_n2: got %b, expected all zero",
                     {wr_en2, addr2, data2, busy2, done2});
        end
        checks++;
        if ({wr_en4, addr4, data4, busy4, done4} !== 19'd0) begin
            errors++;
            $display("FAIL reset_n4: got %b, expected all zero",
                     {wr_en4, addr4, data4, busy4, done4});
        end
        @(posedge clk); #1;
        rst_n2 = 1'b1; rst_n4 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_fill_n2();
        int cyc;
        push2(); nwr2 = 0;
        pulse2();
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, expected 1", busy2);
        end
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (wr_en2 && addr2 == 4'hB) begin
                checks++;
                if (data2 !== 4'd6) begin
                    errors++;
                    $display("FAIL data_at_B: got %0d, expected 6", data2);
                end
            end
            if (wr_en2 && addr2 == 4'hF) begin
                checks++;
                if (data2 !== 4'd9) begin
                    errors++;
                    $display("FAIL data_at_F: got %0d, expected 9", data2);
                end
            end
            if (wr_en2 && addr2 == 4'h3) begin
                checks++;
                if (data2 !== 4'd0) begin
                    errors++;
                    $display("FAIL data_at_3: got %0d, expected 0", data2);
                end
            end
        end
        checks++;
        if (cyc != 64) begin
            errors++;
            $display("FAIL fill_time_n2: got %0d cycles, expected 64", cyc);
        end
        checks++;
        if (nwr2 != 16 || q2.size() != 0) begin
            errors++;
            $display("FAIL writes_n2: got %0d writes, %0d left, expected 16, 0",
                     nwr2, q2.size());
        end
        checks++;
        if (busy2 !== 1'b0 || wr_en2 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: got busy %b wr_en %b, expected 0 0",
                     busy2, wr_en2);
        end
        q2.delete();
    endtask

    task automatic test_full_fill_n4();
        int cyc;
        push4(); nwr4 = 0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 1700) begin
            @(posedge clk); #1; cyc++;
            if (wr_en4 && addr4 == 8'hFF) begin
                checks++;
                if (data4 !== 8'hE1) begin
                    errors++;
                    $display("FAIL data_at_FF: got %h, expected e1", data4);
                end
            end
        end
        checks++;
        if (cyc != 1536) begin
            errors++;
            $display("FAIL fill_time_n4: got %0d cycles, expected 1536", cyc);
        end
        checks++;
        if (nwr4 != 256 || q4.size() != 0) begin
            errors++;
            $display("FAIL writes_n4: got %0d writes, %0d left, expected 256, 0",
                     nwr4, q4.size());
        end
        q4.delete();
    endtask

    task automatic test_stall();
        int cyc;
        bit stalled;
        push2(); nwr2 = 0; n6_2 = 0; stalled = 0;
        pulse2();
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (!stalled && wr_en2 && addr2 == 4'd6) begin
                stalled = 1;
                rdy2 = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1; cyc++;
                    checks++;
                    if (wr_en2 !== 1'b1 || addr2 !== 4'd6 || data2 !== 4'd2) begin
                        errors++;
                        $display("FAIL stall_hold: got en %b addr %0d data %0d, expected 1 6 2",
                                 wr_en2, addr2, data2);
                    end
                end
                rdy2 = 1'b1;
            end
        end
        checks++;
        if (cyc != 69) begin
            errors++;
            $display("FAIL stall_time: got %0d cycles, expected 69", cyc);
        end
        checks++;
        if (n6_2 != 1 || nwr2 != 16) begin
            errors++;
            $display("FAIL stall_writes: got %0d addr6, %0d total, expected 1, 16",
                     n6_2, nwr2);
        end
        q2.delete();
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit pulsed;
        push2(); nwr2 = 0; pulsed = 0;
        pulse2();
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (!pulsed && wr_en2 && addr2 == 4'd3) begin
                pulsed = 1;
                start2 = 1'b1;
                @(posedge clk); #1; cyc++;
                start2 = 1'b0;
            end
        end
        checks++;
        if (cyc != 64 || nwr2 != 16 || q2.size() != 0) begin
            errors++;
            $display("FAIL busy_start: got %0d cycles %0d writes, expected 64, 16",
                     cyc, nwr2);
        end
        q2.delete();
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        push2(); nwr2 = 0;
        pulse2();
        cyc = 0;
        while (!(wr_en2 && addr2 == 4'd9) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (!(wr_en2 && addr2 == 4'd9)) begin
            errors++;
            $display("FAIL reach_addr9: got addr %0d, expected 9", addr2);
        end
        #1 rst_n2 = 1'b0;
        #1;
        checks++;
        if ({wr_en2, addr2, data2, busy2, done2} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected all zero",
                     {wr_en2, addr2, data2, busy2, done2});
        end
        q2.delete();
        @(posedge clk); #3;
        rst_n2 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0 || wr_en2 !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got done %b busy %b en %b, expected 0 0 0",
                     done2, busy2, wr_en2);
        end
        push2(); nwr2 = 0;
        pulse2();
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc != 64 || nwr2 != 16 || q2.size() != 0) begin
            errors++;
            $display("FAIL refill: got %0d cycles %0d writes, expected 64, 16",
                     cyc, nwr2);
        end
        q2.delete();
    endtask

    task automatic test_restart_after_done();
        int cyc;
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky: got %b, expected 1", done2);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done2 !== 1'b1) begin
            errors++;
            $display("FAIL done_held: got %b, expected 1", done2);
        end
        push2(); nwr2 = 0;
        pulse2();
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL restart_flags: got done %b busy %b, expected 0 1",
                     done2, busy2);
        end
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (cyc != 64 || nwr2 != 16 || q2.size() != 0) begin
            errors++;
            $display("FAIL second_fill: got %0d cycles %0d writes, expected 64, 16",
                     cyc, nwr2);
        end
        q2.delete();
    endtask

    initial begin
        test_reset();
        test_full_fill_n2();
        test_full_fill_n4();
        test_stall();
        test_start_while_busy();
        test_reset_mid_fill();
        test_restart_after_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
